// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding, control bundle, NOP bubble values.
// Optional perf counters are enabled with `define PIPE_HAZARD_CTRL_PERF_EN.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERR      = 2'd2
  } state_e;

  // Field values a flushed pipeline register loads to become a bubble
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic        NOP_RF_WE  = 1'b0;
  localparam logic        NOP_DM_WE  = 1'b0;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
  } ctrl_t;

  localparam ctrl_t CTRL_HOLD  = ctrl_t'(7'b000_0000);
  localparam ctrl_t CTRL_RUN   = ctrl_t'(7'b110_1011);
  localparam ctrl_t CTRL_REDIR = ctrl_t'(7'b111_1111);
  localparam ctrl_t CTRL_LU    = ctrl_t'(7'b000_1111);

  function automatic logic src_match(input logic used, input logic [4:0] rs, input logic [4:0] rd);
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stage enables/flushes out.
// Perf counter signals exist only with `define PIPE_HAZARD_CTRL_PERF_EN.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  ex_rf_waddr;
  logic        ex_is_load;
  logic        ex_redirect;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_en;
  logic        if_id_en;
  logic        if_id_flush;
  logic        id_ex_en;
  logic        id_ex_flush;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        mem_err;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rf_waddr, ex_is_load,
           ex_redirect, mem_req, mem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_en, mem_err, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rf_waddr, ex_is_load,
           ex_redirect, mem_req, mem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_en, mem_err, perf_stall_cnt, perf_flush_cnt
  );
`else
  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rf_waddr, ex_is_load,
           ex_redirect, mem_req, mem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_en, mem_err
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rf_waddr, ex_is_load,
           ex_redirect, mem_req, mem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_en, mem_err
  );
`endif
endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: ID reads a register that the load in EX has not yet produced.
// x0 is never a hazard since it is hard-wired to zero.
module load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] ex_rf_waddr,
  input  logic       ex_is_load,
  output logic       lu
);

  assign lu = ex_is_load && (ex_rf_waddr != 5'd0) &&
              (src_match(id_rs1_used, id_rs1, ex_rf_waddr) ||
               src_match(id_rs2_used, id_rs2, ex_rf_waddr));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: memory-wait freeze FSM with watchdog, redirect flush, load-use bubble.
// `define PIPE_HAZARD_CTRL_PERF_EN adds stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave hz
);

  localparam logic [TO_W-1:0] WD_LIMIT = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] WD_ONE   = {{(TO_W-1){1'b0}}, 1'b1};

  state_e          state_r, state_s;
  logic [TO_W-1:0] wd_r, wd_s;
  logic            mem_err_r, mem_err_s;
  logic            lu_s;
  logic            freeze_s;
  ctrl_t           ctrl_s;

  load_use_detect u_load_use_detect (
    .id_rs1      (hz.id_rs1),
    .id_rs2      (hz.id_rs2),
    .id_rs1_used (hz.id_rs1_used),
    .id_rs2_used (hz.id_rs2_used),
    .ex_rf_waddr (hz.ex_rf_waddr),
    .ex_is_load  (hz.ex_is_load),
    .lu          (lu_s)
  );

  // Next state, watchdog count and sticky error
  always_comb begin
    state_s   = state_r;
    wd_s      = wd_r;
    mem_err_s = mem_err_r;
    case (state_r)
      S_RUN: begin
        if (hz.mem_req && !hz.mem_ready) begin
          state_s = S_MEM_WAIT;
          wd_s    = WD_ONE;
        end else begin
          state_s = S_RUN;
        end
      end
      S_MEM_WAIT: begin
        if (hz.mem_ready) begin
          state_s = S_RUN;
        end else if (wd_r == WD_LIMIT) begin
          state_s   = S_ERR;
          mem_err_s = 1'b1;
        end else begin
          wd_s = wd_r + WD_ONE;
        end
      end
      S_ERR: begin
        state_s = S_ERR;
      end
      default: begin
        // Corrupted encoding is treated as a fault, never as a silent run
        state_s   = S_ERR;
        mem_err_s = 1'b1;
      end
    endcase
  end

  // Freeze while a data-memory access is outstanding or after a watchdog fault
  always_comb begin
    freeze_s = 1'b0;
    case (state_r)
      S_RUN:      freeze_s = hz.mem_req && !hz.mem_ready;
      S_MEM_WAIT: freeze_s = !hz.mem_ready;
      default:    freeze_s = 1'b1;
    endcase
  end

  // Priority mux: reset, freeze, redirect, load-use, normal advance
  always_comb begin
    ctrl_s = CTRL_HOLD;
    if (rst) begin
      ctrl_s = CTRL_HOLD;
    end else if (freeze_s) begin
      ctrl_s = CTRL_HOLD;
    end else if (hz.ex_redirect) begin
      ctrl_s = CTRL_REDIR;
    end else if (lu_s) begin
      ctrl_s = CTRL_LU;
    end else begin
      ctrl_s = CTRL_RUN;
    end
  end

  assign hz.pc_en       = ctrl_s.pc_en;
  assign hz.if_id_en    = ctrl_s.if_id_en;
  assign hz.if_id_flush = ctrl_s.if_id_flush;
  assign hz.id_ex_en    = ctrl_s.id_ex_en;
  assign hz.id_ex_flush = ctrl_s.id_ex_flush;
  assign hz.ex_mem_en   = ctrl_s.ex_mem_en;
  assign hz.mem_wb_en   = ctrl_s.mem_wb_en;
  assign hz.mem_err     = mem_err_r;

  // State, watchdog and error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_RUN;
      wd_r      <= {TO_W{1'b0}};
      mem_err_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      wd_r      <= wd_s;
      mem_err_r <= mem_err_s;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_r;
  logic [31:0] perf_flush_r;

  // Stall and flush event counters, wrapping naturally at 2**32
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_r <= 32'd0;
      perf_flush_r <= 32'd0;
    end else begin
      if (freeze_s || lu_s) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
      if (hz.ex_redirect && !freeze_s) begin
        perf_flush_r <= perf_flush_r + 32'd1;
      end
    end
  end

  assign hz.perf_stall_cnt = perf_stall_r;
  assign hz.perf_flush_cnt = perf_flush_r;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver queues hand-computed expectations, negedge monitor checks.
// Define PIPE_HAZARD_CTRL_PERF_EN to also check the perf counters.
module tb_pipe_hazard_ctrl;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_err}
  localparam logic [7:0] E_ZERO  = 8'b0000_0000;
  localparam logic [7:0] E_RUN   = 8'b1101_0110;
  localparam logic [7:0] E_LU    = 8'b0001_1110;
  localparam logic [7:0] E_REDIR = 8'b1111_1110;
  localparam logic [7:0] E_ERR   = 8'b0000_0001;

  typedef struct {
    string       name;
    logic [7:0]  ctrl;
    bit          perf_chk;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .TO_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  // Monitor: every cycle with a queued expectation is compared mid-cycle
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t       e;
      logic [7:0] act;
      e   = sb_q.pop_front();
      act = {hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_en,
             hz.id_ex_flush, hz.ex_mem_en, hz.mem_wb_en, hz.mem_err};
      n_tests++;
      if (act !== e.ctrl) begin
        n_fail++;
        $display("FAIL %s: got %b, expected %b", e.name, act, e.ctrl);
      end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      if (e.perf_chk) begin
        n_tests++;
        if (hz.perf_stall_cnt !== e.stall || hz.perf_flush_cnt !== e.flush) begin
          n_fail++;
          $display("FAIL %s_perf: got stall=%0d flush=%0d, expected stall=%0d flush=%0d",
                   e.name, hz.perf_stall_cnt, hz.perf_flush_cnt, e.stall, e.flush);
        end
      end
`endif
    end
  end

  task automatic idle(input logic r);
    rst            = r;
    hz.id_rs1      = 5'd0;
    hz.id_rs2      = 5'd0;
    hz.id_rs1_used = 1'b0;
    hz.id_rs2_used = 1'b0;
    hz.ex_rf_waddr = 5'd0;
    hz.ex_is_load  = 1'b0;
    hz.ex_redirect = 1'b0;
    hz.mem_req     = 1'b0;
    hz.mem_ready   = 1'b0;
  endtask

  task automatic hazard(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2);
    hz.ex_is_load  = 1'b1;
    hz.ex_rf_waddr = rd;
    hz.id_rs1      = rs1;
    hz.id_rs2      = rs2;
    hz.id_rs1_used = u1;
    hz.id_rs2_used = u2;
  endtask

  task automatic tick_p(input string nm, input logic [7:0] ex, input bit pc,
                        input logic [31:0] st, input logic [31:0] fl);
    sb_q.push_back('{name: nm, ctrl: ex, perf_chk: pc, stall: st, flush: fl});
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input string nm, input logic [7:0] ex);
    tick_p(nm, ex, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    idle(1'b1);
    @(posedge clk);
    #1;

    // Reset and release
    idle(1'b1);  tick("rst_0", E_ZERO);
    idle(1'b1);  tick_p("rst_1", E_ZERO, 1'b1, 32'd0, 32'd0);
    idle(1'b0);  tick("idle_0", E_RUN);
    idle(1'b0);  tick("idle_1", E_RUN);

    // Load-use bubble, then no hazard for x0
    idle(1'b0); hazard(5'd5, 5'd5, 5'd0, 1'b1, 1'b0); tick("lu_rs1", E_LU);
    idle(1'b0);                                       tick("lu_after", E_RUN);
    idle(1'b0); hazard(5'd0, 5'd0, 5'd0, 1'b1, 1'b0); tick("lu_x0", E_RUN);

    // Memory wait: three frozen cycles, released on the fourth
    idle(1'b0); hz.mem_req = 1'b1; tick("mw_run", E_ZERO);
    idle(1'b0); hz.mem_req = 1'b1; tick("mw_w1", E_ZERO);
    idle(1'b0); hz.mem_req = 1'b1; tick("mw_w2", E_ZERO);
    idle(1'b0); hz.mem_req = 1'b1; hz.mem_ready = 1'b1;
    tick_p("mw_release", E_RUN, 1'b1, 32'd4, 32'd0);

    // More load-use patterns
    idle(1'b0); hazard(5'd7, 5'd1, 5'd7, 1'b0, 1'b1); tick("lu_rs2", E_LU);
    idle(1'b0); hazard(5'd7, 5'd7, 5'd7, 1'b0, 1'b0); tick("lu_unused", E_RUN);
    idle(1'b0); hazard(5'd9, 5'd9, 5'd0, 1'b1, 1'b0); hz.ex_is_load = 1'b0;
    tick("lu_not_load", E_RUN);

    // Redirect beats load-use
    idle(1'b0); hazard(5'd5, 5'd5, 5'd0, 1'b1, 1'b0); hz.ex_redirect = 1'b1;
    tick("redir_lu", E_REDIR);

    // Zero-wait access
    idle(1'b0); hz.mem_req = 1'b1; hz.mem_ready = 1'b1; tick("zero_wait", E_RUN);
    idle(1'b0);                                          tick("zero_wait_after", E_RUN);

    // Redirect and load-use held through a freeze, redirect applied on release
    idle(1'b0); hz.mem_req = 1'b1; hz.ex_redirect = 1'b1; hazard(5'd3, 5'd3, 5'd0, 1'b1, 1'b0);
    tick("frz_redir", E_ZERO);
    idle(1'b0); hz.mem_req = 1'b1; hz.mem_ready = 1'b1; hz.ex_redirect = 1'b1;
    tick("frz_release", E_REDIR);
    idle(1'b0);  tick("frz_after", E_RUN);

    // Watchdog timeout with limit 4
    idle(1'b0); hz.mem_req = 1'b1; tick("to_run", E_ZERO);
    for (int i = 1; i <= 4; i++) begin
      idle(1'b0); hz.mem_req = 1'b1; tick($sformatf("to_w%0d", i), E_ZERO);
    end
    idle(1'b0); hz.mem_req = 1'b1; tick("to_err", E_ERR);
    idle(1'b0); hz.mem_ready = 1'b1; hz.ex_redirect = 1'b1; tick("err_sticky", E_ERR);
    idle(1'b1);  tick("err_rst_0", E_ERR);
    idle(1'b1);  tick("err_rst_1", E_ZERO);
    idle(1'b0);  tick("err_rel", E_RUN);

    // Reset in the middle of a wait abandons the access
    idle(1'b0); hz.mem_req = 1'b1; tick("mid_run", E_ZERO);
    idle(1'b0); hz.mem_req = 1'b1; tick("mid_w1", E_ZERO);
    idle(1'b1); hz.mem_req = 1'b1; tick("mid_rst", E_ZERO);
    idle(1'b0);  tick("mid_rel", E_RUN);

    repeat (2) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
